sr_flag_arbiter: RTL and testbench

- Shared bank of NFLAG set/reset flags. Each flag updates like an SR flip-flop: 00 hold, 01 clear, 10 set.
- Up to NREQ requesters compete for write access to the bank. A round-robin arbiter serialises their SR commands, one command per two-cycle transaction.
- Illegal SR encodings (11) and out-of-range addresses are caught and logged. They never corrupt flag state; no X is ever produced.
- Sits between software/control agents and status flags used by downstream datapath logic.

---
 rtl/sr_flag_arbiter_if.sv | 38 +++
 rtl/sr_flag_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter_if
// Request/grant bus between the SR command requesters and the flag bank
// arbiter. The requesters are packed side by side in each vector.
//   req    : per-requester request, held high until ack
//   sr_cmd : per-requester SR code, requester i owns bits [2i+1:2i]
//            (bit1 = S, bit0 = R)
//   addr   : per-requester flag index, requester i owns bits [AW*i+AW-1:AW*i]
//   gnt    : one-hot registered grant from the arbiter
//   ack    : one-cycle completion pulse to the granted requester
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sr_flag_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  sr_cmd;
    logic [AW*NREQ-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;

    modport master (
        output req,
        output sr_cmd,
        output addr,
        input  gnt,
        input  ack
    );

    modport slave (
        input  req,
        input  sr_cmd,
        input  addr,
        output gnt,
        output ack
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
// Shared bank of NFLAG set/reset flags written by up to NREQ requesters.
// A round-robin arbiter grants one requester at a time. Each accepted
// command takes two cycles: one cycle to register the grant (ARB) and one
// cycle to apply the command and pulse ack (GRANT). Illegal SR codes (11)
// and out-of-range addresses never touch the flags; they set sticky error
// bits and bump a saturating error counter.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset
//   bus         : request/grant interface (slave modport)
//   err_clr     : clears the sticky error bits and the error counter
//   q / qbar    : flag values and their complement
//   err_illegal : sticky, an SR=11 command was accepted
//   err_addr    : sticky, an address >= NFLAG was accepted
//   err_cnt     : saturating count of rejected commands
//   busy        : high while in the GRANT state
// ---------------------------------------------------------------------------
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    sr_flag_arbiter_if.slave   bus,
    input  logic               err_clr,
    output logic [NFLAG-1:0]   q,
    output logic [NFLAG-1:0]   qbar,
    output logic               err_illegal,
    output logic               err_addr,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    localparam int             PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0]    NFLAG_LIM = (AW+1)'(NFLAG);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   ack_r;

    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand_idx;
    int                cand;

    logic              cur_req;
    logic [1:0]        cur_cmd;
    logic [AW-1:0]     cur_addr;
    logic              addr_bad;
    logic              cmd_ill;
    logic [NFLAG-1:0]  q_next;

    assign bus.gnt = gnt_r;
    assign bus.ack = ack_r;
    assign qbar    = ~q;
    assign busy    = (state == GRANT);

    // Round-robin pick: scan requesters starting at the pointer and wrapping,
    // first asserted req wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!pick_valid && bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Slice out the granted requester's command and work out the flag bank
    // that would result from applying it. Bad addresses and SR=11 leave the
    // bank untouched.
    always_comb begin
        cur_req  = bus.req[gnt_idx];
        cur_cmd  = bus.sr_cmd[2*int'(gnt_idx) +: 2];
        cur_addr = bus.addr[AW*int'(gnt_idx) +: AW];
        addr_bad = ({1'b0, cur_addr} >= NFLAG_LIM);
        cmd_ill  = (cur_cmd == 2'b11);
        q_next   = q;
        for (int f = 0; f < NFLAG; f++) begin
            if (!addr_bad && (int'(cur_addr) == f)) begin
                case (cur_cmd)
                    2'b01:   q_next[f] = 1'b0;
                    2'b10:   q_next[f] = 1'b1;
                    default: q_next[f] = q[f];
                endcase
            end
        end
    end

    // Main FSM with registered grant/ack/flags/error state. err_clr is applied
    // first so that an error detected in the same cycle overrides it and the
    // counter restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            gnt_r       <= '0;
            ack_r       <= '0;
            q           <= '0;
            err_illegal <= 1'b0;
            err_addr    <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            ack_r <= '0;
            if (err_clr) begin
                err_illegal <= 1'b0;
                err_addr    <= 1'b0;
                err_cnt     <= 8'd0;
            end
            case (state)
                ARB: begin
                    if (pick_valid) begin
                        gnt_r   <= NREQ'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        state   <= GRANT;
                    end else begin
                        gnt_r   <= '0;
                    end
                end
                GRANT: begin
                    gnt_r <= '0;
                    state <= ARB;
                    // A dropped req aborts silently and keeps the pointer
                    if (cur_req) begin
                        ack_r  <= gnt_r;
                        q      <= q_next;
                        rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                        if (cmd_ill) begin
                            err_illegal <= 1'b1;
                        end
                        if (addr_bad) begin
                            err_addr <= 1'b1;
                        end
                        if (cmd_ill || addr_bad) begin
                            if (err_clr) begin
                                err_cnt <= 8'd1;
                            end else if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ARB;
                    gnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Self-checking bench for sr_flag_arbiter with NREQ=4, NFLAG=6, AW=3 so that
// addresses 6 and 7 are out of range. A transaction-level reference model
// runs alongside the DUT every cycle; a hand-written vector table and a few
// directed sequences add fixed expectations for the corner cases.
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              err_clr = 1'b0;
    logic [NFLAG-1:0]  q;
    logic [NFLAG-1:0]  qbar;
    logic              err_illegal;
    logic              err_addr;
    logic [7:0]        err_cnt;
    logic              busy;

    int nCompared   = 0;
    int nMismatched = 0;

    sr_flag_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .q           (q),
        .qbar        (qbar),
        .err_illegal (err_illegal),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model state: the requester currently holding a grant
    // (-1 = none), the round-robin start point, the requester acked this
    // cycle (-1 = none), the flag bank and the error bookkeeping.
    int  mPend   = -1;
    int  mPtr    = 0;
    int  mAckIdx = -1;
    bit  mFlags[NFLAG];
    bit  mIll    = 1'b0;
    bit  mAddr   = 1'b0;
    int  mCnt    = 0;

    typedef struct {
        logic        rs;
        logic [3:0]  req;
        logic [7:0]  sr;
        logic [11:0] addr;
        logic        ec;
        logic [5:0]  q;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        ill;
        logic        ad;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[24];

    // Advance the model by one clock edge using the inputs present now
    task automatic modelStep();
        int  i;
        int  cmd;
        int  a;
        bit  bad;
        bit  ill;
        bit  found;
        if (!rst) begin
            mPend   = -1;
            mPtr    = 0;
            mAckIdx = -1;
            for (int f = 0; f < NFLAG; f++) mFlags[f] = 1'b0;
            mIll  = 1'b0;
            mAddr = 1'b0;
            mCnt  = 0;
            return;
        end
        mAckIdx = -1;
        if (err_clr) begin
            mIll  = 1'b0;
            mAddr = 1'b0;
            mCnt  = 0;
        end
        if (mPend < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                i = (mPtr + k) % NREQ;
                if (!found && bus.req[i]) begin
                    found = 1'b1;
                    mPend = i;
                end
            end
        end else begin
            i     = mPend;
            mPend = -1;
            if (bus.req[i]) begin
                cmd = int'(bus.sr_cmd[2*i +: 2]);
                a   = int'(bus.addr[AW*i +: AW]);
                bad = (a >= NFLAG);
                ill = (cmd == 3);
                if (!bad && cmd == 2) mFlags[a] = 1'b1;
                if (!bad && cmd == 1) mFlags[a] = 1'b0;
                if (ill) mIll = 1'b1;
                if (bad) mAddr = 1'b1;
                if (ill || bad) mCnt = err_clr ? 1 : ((mCnt + 1 > 255) ? 255 : mCnt + 1);
                mAckIdx = i;
                mPtr    = (i + 1) % NREQ;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the reference model
    task automatic checkOutput(input string tag);
        logic [NFLAG-1:0] eq;
        logic [NFLAG-1:0] eqb;
        logic [31:0]      eg;
        logic [31:0]      ea;
        for (int f = 0; f < NFLAG; f++) eq[f] = mFlags[f];
        eqb = ~eq;
        eg  = (mPend >= 0)   ? (32'd1 << mPend)   : 32'd0;
        ea  = (mAckIdx >= 0) ? (32'd1 << mAckIdx) : 32'd0;
        cmp({tag, "_q"},       32'(q),           32'(eq));
        cmp({tag, "_qbar"},    32'(qbar),        32'(eqb));
        cmp({tag, "_gnt"},     32'(bus.gnt),     eg);
        cmp({tag, "_ack"},     32'(bus.ack),     ea);
        cmp({tag, "_errill"},  32'(err_illegal), 32'(mIll));
        cmp({tag, "_erraddr"}, 32'(err_addr),    32'(mAddr));
        cmp({tag, "_errcnt"},  32'(err_cnt),     32'(mCnt));
        cmp({tag, "_busy"},    32'(busy),        32'(mPend >= 0));
    endtask

    // Drive all inputs away from the active edge
    task automatic applyStimulus(input logic rs, input logic [3:0] r, input logic [7:0] c,
                                 input logic [11:0] a, input logic ec);
        @(negedge clk);
        rst        = rs;
        bus.req    = r;
        bus.sr_cmd = c;
        bus.addr   = a;
        err_clr    = ec;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        bus.req    = '0;
        bus.sr_cmd = '0;
        bus.addr   = '0;

        //             rs  req    sr     addr     ec    q      gnt   ack   ill   ad    cnt
        tbl[0]  = '{1'b0, 4'h0, 8'h00, 12'h000, 1'b0, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 4'h1, 8'h02, 12'h003, 1'b0, 6'h00, 4'h1, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'h1, 8'h02, 12'h003, 1'b0, 6'h08, 4'h0, 4'h1, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 4'h0, 8'h00, 12'h000, 1'b0, 6'h08, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 4'h2, 8'h08, 12'h010, 1'b0, 6'h08, 4'h2, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 4'h2, 8'h08, 12'h010, 1'b0, 6'h0C, 4'h0, 4'h2, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 4'h2, 8'h0C, 12'h010, 1'b0, 6'h0C, 4'h2, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 4'h2, 8'h0C, 12'h010, 1'b0, 6'h0C, 4'h0, 4'h2, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 4'h0, 8'h00, 12'h000, 1'b1, 6'h0C, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 4'h1, 8'h02, 12'h007, 1'b0, 6'h0C, 4'h1, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 4'h1, 8'h02, 12'h007, 1'b0, 6'h0C, 4'h0, 4'h1, 1'b0, 1'b1, 8'd1};
        tbl[11] = '{1'b1, 4'h1, 8'h03, 12'h007, 1'b0, 6'h0C, 4'h1, 4'h0, 1'b0, 1'b1, 8'd1};
        tbl[12] = '{1'b1, 4'h1, 8'h03, 12'h007, 1'b0, 6'h0C, 4'h0, 4'h1, 1'b1, 1'b1, 8'd2};
        tbl[13] = '{1'b1, 4'h0, 8'h00, 12'h000, 1'b1, 6'h0C, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 4'h4, 8'h20, 12'h140, 1'b0, 6'h0C, 4'h4, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b1, 4'h0, 8'h20, 12'h140, 1'b0, 6'h0C, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[16] = '{1'b1, 4'h4, 8'h20, 12'h140, 1'b0, 6'h0C, 4'h4, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[17] = '{1'b1, 4'h4, 8'h20, 12'h140, 1'b0, 6'h2C, 4'h0, 4'h4, 1'b0, 1'b0, 8'd0};
        tbl[18] = '{1'b1, 4'h1, 8'h03, 12'h001, 1'b0, 6'h2C, 4'h1, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[19] = '{1'b1, 4'h1, 8'h03, 12'h001, 1'b0, 6'h2C, 4'h0, 4'h1, 1'b1, 1'b0, 8'd1};
        tbl[20] = '{1'b1, 4'h1, 8'h00, 12'h007, 1'b0, 6'h2C, 4'h1, 4'h0, 1'b1, 1'b0, 8'd1};
        tbl[21] = '{1'b1, 4'h1, 8'h00, 12'h007, 1'b1, 6'h2C, 4'h0, 4'h1, 1'b0, 1'b1, 8'd1};
        tbl[22] = '{1'b1, 4'h1, 8'h01, 12'h003, 1'b0, 6'h2C, 4'h1, 4'h0, 1'b0, 1'b1, 8'd1};
        tbl[23] = '{1'b1, 4'h1, 8'h01, 12'h003, 1'b0, 6'h24, 4'h0, 4'h1, 1'b0, 1'b1, 8'd1};

        $display("[TB] vector table");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i].rs, tbl[i].req, tbl[i].sr, tbl[i].addr, tbl[i].ec);
            tick($sformatf("t%0d", i));
            cmp($sformatf("row%0d_q", i),      32'(q),           32'(tbl[i].q));
            cmp($sformatf("row%0d_gnt", i),    32'(bus.gnt),     32'(tbl[i].gnt));
            cmp($sformatf("row%0d_ack", i),    32'(bus.ack),     32'(tbl[i].ack));
            cmp($sformatf("row%0d_errill", i), 32'(err_illegal), 32'(tbl[i].ill));
            cmp($sformatf("row%0d_erradr", i), 32'(err_addr),    32'(tbl[i].ad));
            cmp($sformatf("row%0d_errcnt", i), 32'(err_cnt),     32'(tbl[i].cnt));
            cmp($sformatf("row%0d_busy", i),   32'(busy),        32'(tbl[i].gnt != 4'h0));
        end

        $display("[TB] four requesters, round robin");
        applyStimulus(1'b0, 4'h0, 8'h00, 12'h000, 1'b0);
        tick("rr_rst");
        applyStimulus(1'b1, 4'hF, 8'hAA, 12'h688, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick("rr_g");
            cmp($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'd1 << k);
            tick("rr_a");
            cmp($sformatf("rr_ack%0d", k), 32'(bus.ack), 32'd1 << k);
        end
        cmp("rr_q", 32'(q), 32'h0F);
        tick("rr_wrap");
        cmp("rr_wrap_gnt", 32'(bus.gnt), 32'h1);

        $display("[TB] reset during grant");
        applyStimulus(1'b0, 4'h0, 8'h00, 12'h000, 1'b0);
        tick("rg_rst");
        applyStimulus(1'b1, 4'h2, 8'h08, 12'h008, 1'b0);
        tick("rg_g1");
        tick("rg_a1");
        applyStimulus(1'b1, 4'h4, 8'h20, 12'h100, 1'b0);
        tick("rg_g2");
        cmp("rg_gnt2", 32'(bus.gnt), 32'h4);
        applyStimulus(1'b0, 4'h4, 8'h20, 12'h100, 1'b0);
        tick("rg_inrst");
        cmp("rg_q0",   32'(q),       32'h0);
        cmp("rg_gnt0", 32'(bus.gnt), 32'h0);
        cmp("rg_ack0", 32'(bus.ack), 32'h0);
        applyStimulus(1'b1, 4'hF, 8'hAA, 12'h688, 1'b0);
        tick("rg_restart");
        cmp("rg_restart_gnt", 32'(bus.gnt), 32'h1);

        $display("[TB] error counter saturation");
        applyStimulus(1'b1, 4'h1, 8'h03, 12'h000, 1'b0);
        for (int n = 0; n < 600; n++) tick("sat");
        cmp("sat_cnt", 32'(err_cnt),     32'd255);
        cmp("sat_ill", 32'(err_illegal), 32'd1);
        cmp("sat_q",   32'(q),           32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom % 150) != 0, 4'($urandom), 8'($urandom),
                          12'($urandom), ($urandom % 20) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
